// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: NOP filler halfwords, window and
// consume widths, and the default queue depth.
package fetch_queue_pkg;
  localparam logic [15:0] FQ_NOP_HW_EVEN   = 16'h0013;
  localparam logic [15:0] FQ_NOP_HW_ODD    = 16'h0000;
  localparam int          FQ_WIN_W         = 64;
  localparam int          FQ_CONSUME_W     = 3;
  localparam int          FQ_DEPTH_DEFAULT = 16;
endpackage

// File: rtl/fetch_queue_window_mux.sv
// Rotate/select of four halfword lanes out of a circular source starting at
// head; lanes at or beyond hw_cnt carry the NOP filler pattern.
module fetch_queue_window_mux
  import fetch_queue_pkg::*;
#(
  parameter int SRC_N = FQ_DEPTH_DEFAULT,
  localparam int IDX_W = $clog2(SRC_N)
) (
  input  logic [15:0]             src [SRC_N],
  input  logic [IDX_W-1:0]        head,
  input  logic [FQ_CONSUME_W-1:0] hw_cnt,
  output logic [FQ_WIN_W-1:0]     win
);

  always_comb begin
    win = '0;
    for (int k = 0; k < 4; k++) begin
      if (FQ_CONSUME_W'(k) < hw_cnt)
        win[16*k +: 16] = src[head + IDX_W'(k)];
      else
        win[16*k +: 16] = (k % 2 == 0) ? FQ_NOP_HW_EVEN : FQ_NOP_HW_ODD;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Halfword-granular instruction buffer between I-cache and decode.
// Define FETCH_QUEUE_BYPASS_EN to present packets into an empty queue in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH      = FQ_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Flush,
  input  logic                    Icache_Valid,
  input  logic [ADDR_WIDTH-1:0]   Icache_PC,
  input  logic [FQ_WIN_W-1:0]     Icache_Instr,
  output logic                    FQ_Ready,
  output logic                    FQ_Drop,
  output logic [FQ_WIN_W-1:0]     FQ_Instr,
  output logic [FQ_CONSUME_W-1:0] FQ_HwCount,
  output logic [ADDR_WIDTH-1:0]   FQ_NowPC,
  input  logic [FQ_CONSUME_W-1:0] Decode_Consume
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 4);

  logic [15:0]             storage_q [DEPTH];
  logic [15:0]             storage_d [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]   head_pc_q, head_pc_d, exp_pc_q, exp_pc_d;
  logic                    restart_q, restart_d, drop_q, drop_d;

  logic [1:0]              off;
  logic [15:0]             pkt_hw [4];
  logic                    ready, is_empty, enq_try, enq_ok, bypass;
  logic [FQ_CONSUME_W-1:0] pkt_cnt, st_hw_cnt, win_hw_cnt, n, skip, n_store, added;
  logic [FQ_WIN_W-1:0]     st_win;

  always_comb begin
    off = Icache_PC[2:1];
    for (int k = 0; k < 4; k++) pkt_hw[k] = Icache_Instr[16*k +: 16];
    pkt_cnt   = 3'd4 - {1'b0, off};
    ready     = (count_q <= READY_MAX);
    is_empty  = restart_q || (count_q == '0);
    enq_try   = Icache_Valid && ready && !Flush;
    // A packet into an empty/restarting queue defines a new PC stream.
    enq_ok    = enq_try && (is_empty || (Icache_PC == exp_pc_q));
    st_hw_cnt = (count_q >= CNT_W'(4)) ? 3'd4 : count_q[2:0];
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = enq_ok && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    win_hw_cnt = bypass ? pkt_cnt : st_hw_cnt;
    n          = (Decode_Consume < win_hw_cnt) ? Decode_Consume : win_hw_cnt;
    // Bypassed halfwords consumed this cycle are never stored.
    skip       = bypass ? n : '0;
    n_store    = bypass ? '0 : n;
    added      = enq_ok ? (pkt_cnt - skip) : '0;
  end

  always_comb begin
    storage_d = storage_q;
    for (int k = 0; k < 4; k++) begin
      if (enq_ok && (k >= int'(off) + int'(skip)))
        storage_d[tail_q + PTR_W'(k - int'(off) - int'(skip))] = pkt_hw[k];
    end

    head_d    = head_q + PTR_W'(n_store);
    tail_d    = tail_q + PTR_W'(added);
    count_d   = count_q + CNT_W'(added) - CNT_W'(n_store);
    head_pc_d = ((enq_ok && is_empty) ? Icache_PC : head_pc_q) + ADDR_WIDTH'({n, 1'b0});
    exp_pc_d  = enq_ok ? ({Icache_PC[ADDR_WIDTH-1:3], 3'b000} + ADDR_WIDTH'(8)) : exp_pc_q;
    restart_d = restart_q && !enq_ok;
    drop_d    = enq_try && !enq_ok;

    if (Flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      head_pc_d = head_pc_q;
      exp_pc_d  = exp_pc_q;
      restart_d = 1'b1;
      drop_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
      exp_pc_q  <= '0;
      restart_q <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      exp_pc_q  <= exp_pc_d;
      restart_q <= restart_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) storage_q <= storage_d;

  fetch_queue_window_mux #(.SRC_N(DEPTH)) u_st_mux (
    .src    (storage_q),
    .head   (head_q),
    .hw_cnt (st_hw_cnt),
    .win    (st_win)
  );

`ifdef FETCH_QUEUE_BYPASS_EN
  logic [FQ_WIN_W-1:0] byp_win;

  fetch_queue_window_mux #(.SRC_N(4)) u_byp_mux (
    .src    (pkt_hw),
    .head   (off),
    .hw_cnt (pkt_cnt),
    .win    (byp_win)
  );

  assign FQ_Instr = bypass ? byp_win : st_win;
  assign FQ_NowPC = bypass ? Icache_PC : head_pc_q;
`else
  assign FQ_Instr = st_win;
  assign FQ_NowPC = head_pc_q;
`endif

  assign FQ_Ready   = ready;
  assign FQ_Drop    = drop_q;
  assign FQ_HwCount = win_hw_cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=16): offsets, PC drops,
// full/ready handling, pointer wrap, clamped consume, flush and mid-run reset.
module tb_fetch_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam logic [63:0] NOP_WIN = 64'h0000_0013_0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          Flush;
  logic          Icache_Valid;
  logic [AW-1:0] Icache_PC;
  logic [63:0]   Icache_Instr;
  logic          FQ_Ready;
  logic          FQ_Drop;
  logic [63:0]   FQ_Instr;
  logic [2:0]    FQ_HwCount;
  logic [AW-1:0] FQ_NowPC;
  logic [2:0]    Decode_Consume;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .Flush          (Flush),
    .Icache_Valid   (Icache_Valid),
    .Icache_PC      (Icache_PC),
    .Icache_Instr   (Icache_Instr),
    .FQ_Ready       (FQ_Ready),
    .FQ_Drop        (FQ_Drop),
    .FQ_Instr       (FQ_Instr),
    .FQ_HwCount     (FQ_HwCount),
    .FQ_NowPC       (FQ_NowPC),
    .Decode_Consume (Decode_Consume)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then settle just after the clock edge.
  task automatic cyc(input logic v, input logic [AW-1:0] pc, input logic [63:0] ins,
                     input logic [2:0] cons, input logic fl);
    Icache_Valid   = v;
    Icache_PC      = pc;
    Icache_Instr   = ins;
    Decode_Consume = cons;
    Flush          = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("rst_hwcnt", FQ_HwCount, 0);
    chk("rst_instr", FQ_Instr, NOP_WIN);
    chk("rst_ready", FQ_Ready, 1);
    chk("rst_drop",  FQ_Drop, 0);
    chk("rst_pc",    FQ_NowPC, 0);

    // Aligned packet, no consume.
    cyc(1, 32'h100, 64'h0000_0013_57C1_57C1, 0, 0);
    chk("p100_hwcnt", FQ_HwCount, 4);
    chk("p100_pc",    FQ_NowPC, 32'h100);
    chk("p100_instr", FQ_Instr, 64'h0000_0013_57C1_57C1);
    cyc(0, 0, 0, 4, 0);
    chk("drain_hwcnt", FQ_HwCount, 0);
    chk("drain_pc",    FQ_NowPC, 32'h108);

    // Offset-3 packet into empty queue, then a discontinuous packet.
    cyc(1, 32'h106, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
    chk("p106_hwcnt", FQ_HwCount, 1);
    chk("p106_instr", FQ_Instr, 64'h0000_0013_0000_AAAA);
    chk("p106_pc",    FQ_NowPC, 32'h106);
    cyc(1, 32'h110, 64'h9999_9999_9999_9999, 0, 0);
    chk("p110_drop",  FQ_Drop, 1);
    chk("p110_hwcnt", FQ_HwCount, 1);
    cyc(1, 32'h108, 64'h4444_3333_2222_1111, 0, 0);
    chk("p108_drop",  FQ_Drop, 0);
    chk("p108_hwcnt", FQ_HwCount, 4);
    chk("p108_instr", FQ_Instr, 64'h3333_2222_1111_AAAA);

    // Consume 2 of 5, then enqueue 4 while consuming 3 of 3.
    cyc(0, 0, 0, 2, 0);
    chk("c2_hwcnt", FQ_HwCount, 3);
    chk("c2_pc",    FQ_NowPC, 32'h10A);
    chk("c2_instr", FQ_Instr, 64'h0000_4444_3333_2222);
    cyc(1, 32'h110, 64'h8888_7777_6666_5555, 3, 0);
    chk("enq_cons_hwcnt", FQ_HwCount, 4);
    chk("enq_cons_pc",    FQ_NowPC, 32'h110);
    chk("enq_cons_instr", FQ_Instr, 64'h8888_7777_6666_5555);

    // Fill across the array end up to 14 halfwords.
    cyc(1, 32'h118, 64'hBBB3_BBB2_BBB1_BBB0, 2, 0);
    chk("p118_pc",    FQ_NowPC, 32'h114);
    chk("p118_instr", FQ_Instr, 64'hBBB1_BBB0_8888_7777);
    cyc(1, 32'h120, 64'hCCC3_CCC2_CCC1_CCC0, 0, 0);
    chk("p120_ready", FQ_Ready, 1);
    cyc(1, 32'h128, 64'hDDD3_DDD2_DDD1_DDD0, 0, 0);
    chk("full_ready", FQ_Ready, 0);
    cyc(1, 32'h130, 64'hEEE3_EEE2_EEE1_EEE0, 0, 0);
    chk("ign_drop",  FQ_Drop, 0);
    chk("ign_ready", FQ_Ready, 0);
    chk("ign_instr", FQ_Instr, 64'hBBB1_BBB0_8888_7777);
    cyc(1, 32'h130, 64'hEEE3_EEE2_EEE1_EEE0, 4, 0);
    chk("wrap_ready", FQ_Ready, 1);
    chk("wrap_pc",    FQ_NowPC, 32'h11C);
    chk("wrap_instr", FQ_Instr, 64'hCCC1_CCC0_BBB3_BBB2);
    cyc(1, 32'h130, 64'hEEE3_EEE2_EEE1_EEE0, 4, 0);
    chk("p130_pc",    FQ_NowPC, 32'h124);
    chk("p130_instr", FQ_Instr, 64'hDDD1_DDD0_CCC3_CCC2);
    chk("p130_drop",  FQ_Drop, 0);

    // Flush beats a same-cycle packet and consume.
    cyc(1, 32'h998, 64'h1111_1111_1111_1111, 2, 1);
    chk("flush_hwcnt", FQ_HwCount, 0);
    chk("flush_drop",  FQ_Drop, 0);
    chk("flush_ready", FQ_Ready, 1);
    chk("flush_instr", FQ_Instr, NOP_WIN);
    cyc(1, 32'h200, 64'h1234_5678_9ABC_DEF0, 0, 0);
    chk("p200_pc",    FQ_NowPC, 32'h200);
    chk("p200_hwcnt", FQ_HwCount, 4);
    chk("p200_instr", FQ_Instr, 64'h1234_5678_9ABC_DEF0);

    // Over-request is clamped to the available halfwords.
    cyc(0, 0, 0, 6, 0);
    chk("clamp_hwcnt", FQ_HwCount, 0);
    chk("clamp_pc",    FQ_NowPC, 32'h208);

    // Reset mid-operation with a drop pulse pending.
    cyc(1, 32'h208, 64'h0F0F_0E0E_0D0D_0C0C, 0, 0);
    chk("p208_hwcnt", FQ_HwCount, 4);
    cyc(1, 32'h400, 64'h5555_5555_5555_5555, 0, 0);
    chk("p400_drop", FQ_Drop, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("mrst_drop",  FQ_Drop, 0);
    chk("mrst_hwcnt", FQ_HwCount, 0);
    chk("mrst_pc",    FQ_NowPC, 0);
    chk("mrst_instr", FQ_Instr, NOP_WIN);
    chk("mrst_ready", FQ_Ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
